// File: rtl/sraml_arbiter.sv
// sraml_arbiter
//   Shares one sram-like master port between the instruction-side and
//   data-side sram-like requesters. Only one transaction is in flight at a
//   time; the IDLE cycle between transactions is where the next owner is
//   chosen.
//
//   Arbitration: the side selected by DATA_PRIO wins simultaneous requests,
//   except that after STARVE_LIMIT consecutive preferred grants made while the
//   other side was waiting, the other side is forced through once.
//
// Ports
//   clk, rst                        clock (rising edge), async active-low reset
//   inst_* / data_*                 requester sides: req, wr, size, addr, wdata in;
//                                   addr_ok, data_ok, rdata out
//   m_req, m_wr, m_size,
//   m_addr, m_wdata                 master request, valid only while in ADDR
//   m_addr_ok, m_data_ok, m_rdata   master handshakes and read data
module sraml_arbiter #(
    parameter int DATA_PRIO    = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    // owner / preference encoding: 0 = inst, 1 = data
    localparam logic       PREF  = (DATA_PRIO != 0);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state;
    logic       owner;
    logic [3:0] starve_cnt;

    logic pref_req, oth_req, own_req;
    logic in_addr, in_wait, data_fire;

    assign pref_req = PREF ? data_req : inst_req;
    assign oth_req  = PREF ? inst_req : data_req;
    assign own_req  = owner ? data_req : inst_req;

    assign in_addr  = (state == ADDR);
    assign in_wait  = (state == WAIT);

    // A slave may finish the whole transfer in the address cycle; that
    // completion is forwarded exactly like a normal WAIT-state data_ok.
    assign data_fire = (in_wait & m_data_ok) | (in_addr & m_addr_ok & m_data_ok);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req | data_req) begin
                        state <= ADDR;
                        if (pref_req && oth_req) begin
                            if (starve_cnt == LIMIT) begin
                                owner      <= ~PREF;
                                starve_cnt <= 4'd0;
                            end else begin
                                // cnt < LIMIT here, so this never overshoots
                                owner      <= PREF;
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            owner      <= pref_req ? PREF : ~PREF;
                            starve_cnt <= 4'd0;
                        end
                    end
                end
                ADDR: begin
                    if (m_addr_ok)
                        state <= m_data_ok ? IDLE : WAIT;
                    else if (!own_req)
                        state <= IDLE;   // requester withdrew: no handshake
                end
                WAIT: begin
                    if (m_data_ok)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Master command: owner's inputs while in ADDR, all zero otherwise.
    assign m_req   = in_addr & own_req;
    assign m_wr    = in_addr & (owner ? data_wr : inst_wr);
    assign m_size  = in_addr ? (owner ? data_size  : inst_size)  : 2'b00;
    assign m_addr  = in_addr ? (owner ? data_addr  : inst_addr)  : 32'd0;
    assign m_wdata = in_addr ? (owner ? data_wdata : inst_wdata) : 32'd0;

    // Handshakes are routed only to the owner and only in the matching state.
    assign inst_addr_ok = in_addr & ~owner & m_addr_ok;
    assign data_addr_ok = in_addr &  owner & m_addr_ok;
    assign inst_data_ok = data_fire & ~owner;
    assign data_data_ok = data_fire &  owner;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

endmodule

// File: tb/tb_sraml_arbiter.sv
// Bench for sraml_arbiter: per-side requester agents and a randomized slave
// drive the DUT; every issued transaction is pushed to a per-side expectation
// queue and a separate monitor process checks the master command, handshake
// routing, read data and grant order against a transaction-level model.
module tb_sraml_arbiter;
    localparam int DATA_PRIO    = 1;
    localparam int STARVE_LIMIT = 4;
    localparam int PREF         = DATA_PRIO;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } dchk_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        r_req[2];
    logic        r_wr[2];
    logic [1:0]  r_size[2];
    logic [31:0] r_addr[2];
    logic [31:0] r_wdata[2];
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;

    sraml_arbiter #(.DATA_PRIO(DATA_PRIO), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(r_req[0]), .inst_wr(r_wr[0]), .inst_size(r_size[0]),
        .inst_addr(r_addr[0]), .inst_wdata(r_wdata[0]),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(r_req[1]), .data_wr(r_wr[1]), .data_size(r_size[1]),
        .data_addr(r_addr[1]), .data_wdata(r_wdata[1]),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    // ---------------- shared bench state ----------------
    txn_t  iss_q[2][$];     // waiting to be issued by the agents (main only)
    txn_t  exp_q[2][$];     // issued, expected at the master (main pushes)
    int    rd_idx[2];       // monitor's read pointer into exp_q
    dchk_t dir_q[$];        // directed expectations (main pushes)
    int    glog[$];         // side of every observed addr handshake
    int    n_dok[2];        // observed data_ok pulses per side
    int    n_comb;          // observed same-cycle addr_ok+data_ok to one side
    int    mph;             // model phase: 0 idle, 1 address, 2 wait
    int    checks, errors;
    logic  done;

    // agent / slave knobs
    int   gap[2];
    int   gap_max, amin, amax, dmin, dmax, comb_pct;
    logic slave_en;
    int   sph, acnt, dcnt;
    logic scomb;
    logic [31:0] saddr;

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h3C08_0001;
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic txn_t mk(input logic wr, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
        txn_t t;
        t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata; t.rdata = rd_of(addr);
        return t;
    endfunction

    function automatic int gl(input int i);
        return (glog.size() > i) ? glog[i] : 9;
    endfunction

    function automatic logic idle_all();
        return iss_q[0].size() == 0 && iss_q[1].size() == 0 &&
               exp_q[0].size() == rd_idx[0] && exp_q[1].size() == rd_idx[1] &&
               mph == 0 && !r_req[0] && !r_req[1];
    endfunction

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        dchk_t d;
        d.nm = nm; d.act = act; d.exp = exp;
        dir_q.push_back(d);
    endtask

    // One clock of stimulus: sample at negedge, agents at +1, slave at +2.
    task automatic step();
        logic aok[2];
        logic smreq, smaok, smdok;
        @(negedge clk);
        aok[0] = inst_addr_ok; aok[1] = data_addr_ok;
        smreq = m_req; smaok = m_addr_ok; smdok = m_data_ok;
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            if (r_req[s] && aok[s]) r_req[s] = 1'b0;
            if (!r_req[s]) begin
                if (gap[s] > 0) gap[s]--;
                else if (iss_q[s].size() > 0) begin
                    txn_t t;
                    t = iss_q[s].pop_front();
                    r_wr[s] = t.wr; r_size[s] = t.size; r_addr[s] = t.addr; r_wdata[s] = t.wdata;
                    r_req[s] = 1'b1;
                    exp_q[s].push_back(t);
                    gap[s] = $urandom_range(gap_max, 0);
                end
            end
        end
        #1;
        if (slave_en) begin
            if (smreq && smaok) begin
                sph  = smdok ? 0 : 2;
                dcnt = $urandom_range(dmax, dmin);
            end else if (sph == 2 && smdok) sph = 0;
            m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = $urandom;
            if (sph == 0 && m_req) begin
                sph = 1; acnt = $urandom_range(amax, amin);
                scomb = ($urandom_range(99, 0) < comb_pct);
            end
            if (sph == 1) begin
                if (!m_req) sph = 0;
                else if (acnt == 0) begin
                    m_addr_ok = 1'b1; saddr = m_addr;
                    if (scomb) begin m_data_ok = 1'b1; m_rdata = rd_of(m_addr); end
                end else acnt--;
            end else if (sph == 2) begin
                if (dcnt == 0) begin m_data_ok = 1'b1; m_rdata = rd_of(saddr); end
                else dcnt--;
            end
        end
    endtask

    task automatic drain(input int max, input string nm);
        int n;
        n = 0;
        while (!idle_all() && n < max) begin step(); n++; end
        dchk(nm, 32'(idle_all()), 32'd1);
    endtask

    task automatic knobs(input int gm, input int a0, input int a1, input int d0, input int d1, input int cp);
        gap_max = gm; amin = a0; amax = a1; dmin = d0; dmax = d1; comb_pct = cp;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin : monitor
        int   mown, scnt;
        logic ir, dr, comb, own_dok;
        txn_t t;
        logic [31:0] exp_rd;
        mown = 0; scnt = 0; exp_rd = '0; mph = 0;
        forever begin
            @(negedge clk);
            while (dir_q.size() > 0) begin
                dchk_t d;
                d = dir_q.pop_front();
                chk(d.nm, 128'(d.act), 128'(d.exp));
            end
            if (done) break;
            if (inst_addr_ok) glog.push_back(0);
            if (data_addr_ok) glog.push_back(1);
            n_dok[0] += int'(inst_data_ok);
            n_dok[1] += int'(data_data_ok);
            n_comb   += int'((inst_addr_ok & inst_data_ok) | (data_addr_ok & data_data_ok));
            chk("rdata_passthru", {inst_rdata, data_rdata}, {m_rdata, m_rdata});
            if (!rst) begin
                chk("reset_outputs", {m_req, m_wr, m_size, m_addr, m_wdata,
                    inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, '0);
                mph = 0; scnt = 0;
            end else begin
                case (mph)
                    0: begin
                        chk("idle_outputs", {m_req, inst_addr_ok, data_addr_ok,
                            inst_data_ok, data_data_ok}, '0);
                        ir = r_req[0]; dr = r_req[1];
                        if (ir || dr) begin
                            // preferred side wins ties until it has won
                            // STARVE_LIMIT ties in a row, then the other side
                            if (ir && dr) begin
                                if (scnt == STARVE_LIMIT) begin mown = 1 - PREF; scnt = 0; end
                                else begin mown = PREF; scnt++; end
                            end else begin
                                mown = dr ? 1 : 0; scnt = 0;
                            end
                            mph = 1;
                        end
                    end
                    1: begin
                        chk("m_req_addr", m_req, 1'b1);
                        if (rd_idx[mown] < exp_q[mown].size()) begin
                            t = exp_q[mown][rd_idx[mown]];
                            chk("m_cmd", {m_wr, m_size, m_addr, m_wdata},
                                {t.wr, t.size, t.addr, t.wdata});
                        end else begin
                            chk("grant_without_txn", 128'(rd_idx[mown]), 128'(exp_q[mown].size()));
                            t = mk(1'b0, 2'b0, 32'd0, 32'd0);
                        end
                        chk("addr_ok_route", {inst_addr_ok, data_addr_ok},
                            (mown == 1) ? {1'b0, m_addr_ok} : {m_addr_ok, 1'b0});
                        comb = m_addr_ok & m_data_ok;
                        chk("data_ok_addrphase", {inst_data_ok, data_data_ok},
                            (mown == 1) ? {1'b0, comb} : {comb, 1'b0});
                        if (m_addr_ok) begin
                            rd_idx[mown]++;
                            exp_rd = t.rdata;
                            if (comb) begin
                                chk("rdata_comb", (mown == 1) ? data_rdata : inst_rdata, exp_rd);
                                mph = 0;
                            end else mph = 2;
                        end else if (!m_req) mph = 0;
                    end
                    default: begin
                        chk("wait_outputs", {m_req, inst_addr_ok, data_addr_ok}, '0);
                        own_dok = m_data_ok;
                        chk("data_ok_route", {inst_data_ok, data_data_ok},
                            (mown == 1) ? {1'b0, own_dok} : {own_dok, 1'b0});
                        if (m_data_ok) begin
                            chk("rdata", (mown == 1) ? data_rdata : inst_rdata, exp_rd);
                            mph = 0;
                        end
                    end
                endcase
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int g0, d0, d1, c0, n;
        checks = 0; errors = 0; done = 1'b0;
        n_comb = 0;
        for (int s = 0; s < 2; s++) begin
            r_req[s] = 0; r_wr[s] = 0; r_size[s] = 0; r_addr[s] = 0; r_wdata[s] = 0;
            gap[s] = 0; rd_idx[s] = 0; n_dok[s] = 0;
        end
        sph = 0; acnt = 0; dcnt = 0; scomb = 0; saddr = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        slave_en = 0; rst = 0;
        knobs(0, 0, 2, 0, 2, 0);

        // Reset held 3 cycles with both requests and m_addr_ok high.
        iss_q[1].push_back(mk(1'b1, 2'd2, 32'h8000_0040, 32'hCAFE_0001));
        iss_q[0].push_back(mk(1'b0, 2'd2, 32'hBFC0_0100, 32'd0));
        m_addr_ok = 1'b1;
        repeat (3) step();
        rst = 1'b1; m_addr_ok = 1'b0; slave_en = 1'b1;
        g0 = glog.size();
        drain(200, "drain_reset");
        dchk("first_grant_data", 32'(gl(g0)), 32'd1);
        dchk("second_grant_inst", 32'(gl(g0 + 1)), 32'd0);

        // Single inst read.
        knobs(0, 2, 2, 3, 3, 0);
        d0 = n_dok[0]; d1 = n_dok[1];
        iss_q[0].push_back(mk(1'b0, 2'd2, 32'hBFC0_0000, 32'd0));
        drain(200, "drain_single");
        dchk("single_inst_dok", 32'(n_dok[0] - d0), 32'd1);
        dchk("single_data_dok", 32'(n_dok[1] - d1), 32'd0);

        // Simultaneous data write and inst read.
        knobs(0, 0, 2, 0, 2, 0);
        g0 = glog.size();
        iss_q[1].push_back(mk(1'b1, 2'd2, 32'h8000_1000, 32'h1234_5678));
        iss_q[0].push_back(mk(1'b0, 2'd2, 32'hBFC0_0004, 32'd0));
        drain(200, "drain_both");
        dchk("both_first_data", 32'(gl(g0)), 32'd1);
        dchk("both_then_inst", 32'(gl(g0 + 1)), 32'd0);

        // Starvation guard: both sides requesting back to back.
        knobs(0, 0, 1, 0, 1, 0);
        g0 = glog.size();
        for (int k = 0; k < 6; k++)
            iss_q[1].push_back(mk(1'b0, 2'd2, 32'h8000_2000 + 32'(k * 4), 32'd0));
        for (int k = 0; k < 2; k++)
            iss_q[0].push_back(mk(1'b0, 2'd2, 32'hBFC0_1000 + 32'(k * 4), 32'd0));
        drain(400, "drain_starve");
        for (int k = 0; k < 6; k++)
            dchk($sformatf("starve_order_%0d", k), 32'(gl(g0 + k)), (k == 4) ? 32'd0 : 32'd1);

        // Address and data accepted in the same cycle.
        knobs(0, 1, 1, 0, 0, 100);
        c0 = n_comb;
        iss_q[1].push_back(mk(1'b0, 2'd2, 32'h8000_3000, 32'd0));
        iss_q[0].push_back(mk(1'b1, 2'd1, 32'hBFC0_2002, 32'hA5A5_0F0F));
        drain(200, "drain_comb");
        dchk("comb_count", 32'(n_comb - c0), 32'd2);

        // Reset during WAIT, then a stray m_data_ok.
        knobs(0, 0, 0, 20, 20, 0);
        iss_q[0].push_back(mk(1'b0, 2'd2, 32'h9FC0_0200, 32'd0));
        n = 0;
        while (mph != 2 && n < 50) begin step(); n++; end
        dchk("reached_wait", 32'(mph), 32'd2);
        step(); step();
        rst = 1'b0; slave_en = 1'b0; sph = 0;
        r_req[0] = 0; r_req[1] = 0; m_addr_ok = 0; m_data_ok = 0;
        step(); step();
        rst = 1'b1;
        d0 = n_dok[0]; d1 = n_dok[1];
        m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
        step();
        m_data_ok = 1'b0;
        step(); step();
        dchk("stray_inst_dok", 32'(n_dok[0] - d0), 32'd0);
        dchk("stray_data_dok", 32'(n_dok[1] - d1), 32'd0);
        slave_en = 1'b1;
        knobs(0, 0, 2, 0, 2, 0);
        g0 = glog.size();
        iss_q[1].push_back(mk(1'b0, 2'd2, 32'h8000_4000, 32'd0));
        drain(200, "drain_after_reset");
        dchk("post_reset_grant", 32'(gl(g0)), 32'd1);
        dchk("post_reset_dok", 32'(n_dok[1] - d1), 32'd1);

        // Random traffic on both sides.
        knobs(3, 0, 3, 0, 3, 25);
        for (int k = 0; k < 100; k++)
            for (int s = 0; s < 2; s++)
                iss_q[s].push_back(mk(1'($urandom_range(1, 0)), 2'($urandom_range(2, 0)),
                                      $urandom & 32'hFFFF_FFFC, $urandom));
        drain(8000, "drain_random");

        step();
        done = 1'b1;
    end

endmodule
